// File: rtl/branch_update_queue_pkg.sv
// Shared branch-predictor core types: queue entry layout, default widths and PHT counter encodings.
package branch_update_queue_pkg;

   localparam int unsigned WIDTH_DEF     = 31;
   localparam int unsigned IDX_WIDTH_DEF = 7;
   localparam int unsigned DEPTH_DEF     = 4;

   localparam int unsigned ENTRY_AW = WIDTH_DEF + 1;
   localparam int unsigned ENTRY_IW = IDX_WIDTH_DEF + 1;

   // Two-bit saturating PHT counter states
   typedef enum logic [1:0] {
      PHT_STRONG_NT = 2'b00,
      PHT_WEAK_NT   = 2'b01,
      PHT_WEAK_T    = 2'b10,
      PHT_STRONG_T  = 2'b11
   } pht_state_e;

   // One pending predictor-table update
   typedef struct packed {
      logic                is_branch;
      logic                write_btb;
      logic                taken;
      pht_state_e          next_state;
      logic [ENTRY_IW-1:0] index;
      logic [ENTRY_AW-1:0] target;
   } bu_entry_t;

endpackage

// File: rtl/branch_update_queue_update_fifo.sv
// Generic power-of-two FIFO with push/pop/flush used to buffer predictor table updates.
module update_fifo #(
   parameter type         entry_t = logic,
   parameter int unsigned DEPTH   = 4
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   flush_i,
   input  logic   push_i,
   input  logic   pop_i,
   input  entry_t data_i,
   output entry_t data_o,
   output logic   full_o,
   output logic   empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push_ok_c;
   logic            pop_ok_c;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign push_ok_c = push_i & ~full_o & ~flush_i;
   assign pop_ok_c  = pop_i & ~empty_o & ~flush_i;
   assign data_o    = mem_q[rd_ptr_q];

   // Pointer/count next state; flush wins over push and pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok_c) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PW'(1);
         unique case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are meaningless outside the valid window so no reset
   always_ff @(posedge clk) begin
      if (reset_n && push_ok_c) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/branch_update_queue.sv
// Branch update queue: buffers branch ALU outcomes until the predictor tables accept a
// write, and produces a one-cycle redirect on mispredict.
// Optional feature macro: BRANCH_UPDATE_BYPASS_EN (same-cycle table write when queue is idle).
module branch_update_queue
   import branch_update_queue_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned IDX_WIDTH = IDX_WIDTH_DEF,
   parameter int unsigned DEPTH     = DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 request,
   input  logic                 isBranch,
   input  logic                 mispredictIn,
   input  logic                 takenBranch,
   input  logic                 writeBTB,
   input  logic [1:0]           nextState,
   input  logic [WIDTH:0]       correctAddress,
   input  logic [IDX_WIDTH:0]   tableIndex,
   input  logic                 flushAll,
   input  logic                 tblReady,
   output logic                 phtWE,
   output logic                 btbWE,
   output logic                 btbValid,
   output logic [IDX_WIDTH:0]   wrIndex,
   output logic [1:0]           wrState,
   output logic [WIDTH:0]       wrTarget,
   output logic                 redirect,
   output logic [WIDTH:0]       redirectPC,
   output logic                 full,
   output logic                 overflow
);

   localparam int unsigned AW = WIDTH + 1;
   localparam int unsigned IW = IDX_WIDTH + 1;

   bu_entry_t      enq_entry;
   bu_entry_t      head_entry;
   logic           fifo_full;
   logic           fifo_empty;
   logic           qualify_c;
   logic           bypass_c;
   logic           push_c;
   logic           pop_c;
   logic           overflow_q, overflow_d;
   logic           redirect_q, redirect_d;
   logic [WIDTH:0] redirect_pc_q, redirect_pc_d;

   assign qualify_c = request & (isBranch | writeBTB);

`ifdef BRANCH_UPDATE_BYPASS_EN
   assign bypass_c = qualify_c & fifo_empty & tblReady & ~flushAll & reset_n;
`else
   assign bypass_c = 1'b0;
`endif

   assign push_c = qualify_c & ~fifo_full & ~flushAll & ~bypass_c;
   assign pop_c  = ~fifo_empty & tblReady & ~flushAll & reset_n;

   // Pack the incoming ALU result into a queue entry
   always_comb begin
      enq_entry            = '0;
      enq_entry.is_branch  = isBranch;
      enq_entry.write_btb  = writeBTB;
      enq_entry.taken      = takenBranch;
      enq_entry.next_state = pht_state_e'(nextState);
      enq_entry.index      = ENTRY_IW'(tableIndex);
      enq_entry.target     = ENTRY_AW'(correctAddress);
   end

   update_fifo #(
      .entry_t (bu_entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (flushAll),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .data_i  (enq_entry),
      .data_o  (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Table write port: queue head when draining, live result when bypassing
   always_comb begin
      phtWE    = 1'b0;
      btbWE    = 1'b0;
      btbValid = 1'b0;
      wrIndex  = IW'(head_entry.index);
      wrState  = head_entry.next_state;
      wrTarget = AW'(head_entry.target);
      if (pop_c) begin
         phtWE    = head_entry.is_branch;
         btbWE    = head_entry.write_btb;
         btbValid = head_entry.taken;
      end else if (bypass_c) begin
         phtWE    = isBranch;
         btbWE    = writeBTB;
         btbValid = takenBranch;
         wrIndex  = tableIndex;
         wrState  = nextState;
         wrTarget = correctAddress;
      end
   end

   // Sticky overflow and one-cycle redirect next state
   always_comb begin
      overflow_d    = overflow_q | (qualify_c & fifo_full);
      redirect_d    = request & mispredictIn;
      redirect_pc_d = redirect_pc_q;
      if (request && mispredictIn) redirect_pc_d = correctAddress;
   end

   // Status and redirect registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overflow_q    <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         overflow_q    <= overflow_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign full       = fifo_full;
   assign overflow   = overflow_q;
   assign redirect   = redirect_q;
   assign redirectPC = redirect_pc_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench for branch_update_queue (default build, queue path only).
module tb_branch_update_queue;

   logic        clk;
   logic        reset_n;
   logic        request;
   logic        isBranch;
   logic        mispredictIn;
   logic        takenBranch;
   logic        writeBTB;
   logic [1:0]  nextState;
   logic [31:0] correctAddress;
   logic [7:0]  tableIndex;
   logic        flushAll;
   logic        tblReady;
   logic        phtWE;
   logic        btbWE;
   logic        btbValid;
   logic [7:0]  wrIndex;
   logic [1:0]  wrState;
   logic [31:0] wrTarget;
   logic        redirect;
   logic [31:0] redirectPC;
   logic        full;
   logic        overflow;

   typedef struct {
      logic [44:0] v;
      int          cyc;
   } wexp_t;

   typedef struct {
      logic [31:0] pc;
      int          cyc;
   } rexp_t;

   wexp_t wq[$];
   rexp_t rq[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    cyc   = 0;

   branch_update_queue dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .request        (request),
      .isBranch       (isBranch),
      .mispredictIn   (mispredictIn),
      .takenBranch    (takenBranch),
      .writeBTB       (writeBTB),
      .nextState      (nextState),
      .correctAddress (correctAddress),
      .tableIndex     (tableIndex),
      .flushAll       (flushAll),
      .tblReady       (tblReady),
      .phtWE          (phtWE),
      .btbWE          (btbWE),
      .btbValid       (btbValid),
      .wrIndex        (wrIndex),
      .wrState        (wrState),
      .wrTarget       (wrTarget),
      .redirect       (redirect),
      .redirectPC     (redirectPC),
      .full           (full),
      .overflow       (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every table write and every redirect must match the next expected item
   always @(negedge clk) begin
      logic [44:0] got;
      wexp_t       we;
      rexp_t       re;
      if (phtWE === 1'b1 || btbWE === 1'b1 || btbValid === 1'b1) begin
         got = {phtWE, btbWE, btbValid, wrState, wrIndex, wrTarget};
         n_cmp++;
         if (wq.size() == 0) begin
            n_err++;
            $display("FAIL write_unexpected cyc=%0d got=%h required=no write", cyc, got);
         end else begin
            we = wq.pop_front();
            if (got !== we.v || (we.cyc >= 0 && cyc != we.cyc)) begin
               n_err++;
               $display("FAIL table_write cyc=%0d got=%h required=%h at cyc %0d", cyc, got, we.v, we.cyc);
            end
         end
      end
      if (redirect === 1'b1) begin
         n_cmp++;
         if (rq.size() == 0) begin
            n_err++;
            $display("FAIL redirect_unexpected cyc=%0d pc=%h", cyc, redirectPC);
         end else begin
            re = rq.pop_front();
            if (redirectPC !== re.pc || cyc != re.cyc) begin
               n_err++;
               $display("FAIL redirect cyc=%0d pc=%h required pc=%h at cyc %0d", cyc, redirectPC, re.pc, re.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h required=%h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      request        = 1'b0;
      isBranch       = 1'b0;
      mispredictIn   = 1'b0;
      takenBranch    = 1'b0;
      writeBTB       = 1'b0;
      nextState      = 2'b00;
      correctAddress = 32'h0;
      tableIndex     = 8'h0;
   endtask

   task automatic drive(input logic ib, input logic wb, input logic tk, input logic [1:0] st,
                        input logic [7:0] idx, input logic [31:0] addr, input logic misp);
      request        = 1'b1;
      isBranch       = ib;
      writeBTB       = wb;
      takenBranch    = tk;
      nextState      = st;
      tableIndex     = idx;
      correctAddress = addr;
      mispredictIn   = misp;
   endtask

   task automatic expect_write(input logic ib, input logic wb, input logic tk, input logic [1:0] st,
                               input logic [7:0] idx, input logic [31:0] addr, input int at);
      wexp_t e;
      e.v   = {ib, wb, tk, st, idx, addr};
      e.cyc = at;
      wq.push_back(e);
   endtask

   task automatic expect_redirect(input logic [31:0] pc, input int at);
      rexp_t e;
      e.pc  = pc;
      e.cyc = at;
      rq.push_back(e);
   endtask

   initial begin
      idle_inputs();
      reset_n  = 1'b0;
      flushAll = 1'b0;
      tblReady = 1'b0;
      step();
      step();
      @(negedge clk);
      check("reset_full", 32'(full), 32'h0);
      check("reset_overflow", 32'(overflow), 32'h0);
      check("reset_redirect", 32'(redirect), 32'h0);
      check("reset_redirectPC", redirectPC, 32'h0);
      check("reset_writes", 32'({phtWE, btbWE, btbValid}), 32'h0);
      step();
      reset_n  = 1'b1;
      tblReady = 1'b1;

      // Single taken branch, empty queue: write one cycle later
      step();
      drive(1'b1, 1'b1, 1'b1, 2'b11, 8'h2A, 32'h0000_0100, 1'b0);
      expect_write(1'b1, 1'b1, 1'b1, 2'b11, 8'h2A, 32'h0000_0100, cyc + 1);
      step();
      idle_inputs();
      step();

      // Mispredicting JALR (no table update) -> one-cycle redirect only
      drive(1'b0, 1'b0, 1'b0, 2'b00, 8'h11, 32'h0000_2000, 1'b1);
      expect_redirect(32'h0000_2000, cyc + 1);
      step();
      idle_inputs();
      @(negedge clk);
      check("redirectPC_hold", redirectPC, 32'h0000_2000);
      step();
      step();

      // Fill with tables stalled; fifth request overflows
      tblReady = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         drive(1'b1, k[0], k[0], k[1:0], 8'(k + 1), 32'h1000 + 32'(k * 4), 1'b0);
         if (k < 4) expect_write(1'b1, k[0], k[0], k[1:0], 8'(k + 1), 32'h1000 + 32'(k * 4), -1);
         @(negedge clk);
         check($sformatf("fill_full_%0d", k), 32'(full), (k == 4) ? 32'h1 : 32'h0);
      end
      step();
      idle_inputs();
      @(negedge clk);
      check("overflow_set", 32'(overflow), 32'h1);
      check("full_after_drop", 32'(full), 32'h1);
      step();
      tblReady = 1'b1;
      @(negedge clk);
      check("full_during_first_drain", 32'(full), 32'h1);
      step();
      @(negedge clk);
      check("full_after_first_drain", 32'(full), 32'h0);
      for (int k = 0; k < 4; k++) step();

      // Three entries then flush; coincident request dropped, redirect still produced
      tblReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         drive(1'b1, 1'b0, 1'b0, 2'b01, 8'h40 + 8'(k), 32'h2200 + 32'(k), 1'b0);
      end
      step();
      idle_inputs();
      step();
      flushAll = 1'b1;
      tblReady = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 2'b10, 8'h55, 32'h0000_3000, 1'b1);
      expect_redirect(32'h0000_3000, cyc + 1);
      step();
      flushAll = 1'b0;
      idle_inputs();
      @(negedge clk);
      check("flush_full", 32'(full), 32'h0);
      check("flush_overflow_kept", 32'(overflow), 32'h1);
      step();
      drive(1'b0, 1'b1, 1'b1, 2'b00, 8'h77, 32'h0000_4444, 1'b0);
      expect_write(1'b0, 1'b1, 1'b1, 2'b00, 8'h77, 32'h0000_4444, cyc + 1);
      step();
      idle_inputs();
      step();

      // JAL result is never queued
      drive(1'b0, 1'b0, 1'b1, 2'b11, 8'h99, 32'h0000_5000, 1'b0);
      step();
      idle_inputs();
      step();

      // Nine back-to-back enqueue/dequeue pairs wrap the pointers twice
      for (int i = 0; i < 9; i++) begin
         logic ib, wb;
         ib = (i % 3) != 1;
         wb = (i % 3) != 0;
         drive(ib, wb, i[0], i[1:0], 8'hC0 + 8'(i), 32'h8000 + 32'(i * 16), 1'b0);
         expect_write(ib, wb, i[0], i[1:0], 8'hC0 + 8'(i), 32'h8000 + 32'(i * 16), cyc + 1);
         step();
      end
      idle_inputs();
      step();
      step();

      // Reset with two entries queued and a redirect pending
      tblReady = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 2'b10, 8'hA1, 32'h0000_6100, 1'b0);
      step();
      drive(1'b1, 1'b1, 1'b1, 2'b11, 8'hA2, 32'h0000_6200, 1'b0);
      step();
      reset_n  = 1'b0;
      tblReady = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 2'b00, 8'hA3, 32'h0000_6000, 1'b1);
      step();
      idle_inputs();
      @(negedge clk);
      check("rst_mid_redirect", 32'(redirect), 32'h0);
      check("rst_mid_redirectPC", redirectPC, 32'h0);
      check("rst_mid_full", 32'(full), 32'h0);
      check("rst_mid_overflow", 32'(overflow), 32'h0);
      step();
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_release_writes", 32'({phtWE, btbWE, btbValid}), 32'h0);
      for (int k = 0; k < 4; k++) step();

      check("writes_outstanding", 32'(wq.size()), 32'h0);
      check("redirects_outstanding", 32'(rq.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
